md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  E-stage multiply/divide unit with architectural HI/LO registers.
//  Consumes the forwarded E-stage operands: RD1/RD2 after the F_ALU_A_E/F_ALU_B_E muxes.
//  Models fixed multi-cycle latency and raises busy, which the stall unit uses to hold
//  mult/div/mfhi/mflo/mthi/mtlo in D. hi/lo feed the mfhi/mflo result path into the M register.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   rising-edge clock
//  reset     in   1   asynchronous, active-high reset
//  start     in   1   valid E-stage mult/div/mthi/mtlo this cycle
//  md_op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved
//  a         in   32  forwarded rs operand (E)
//  b         in   32  forwarded rt operand (E)
//  busy      out  1   operation in flight
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-operation):
//    - busy=0, hi=0, lo=0, counter=0, state IDLE.
//    - Pending result is discarded.
//  - FSM states:
//    - IDLE: busy=0.
//    - RUN: busy=1, counter counts down.
//  - IDLE & start & md_op in {0..3}:
//    - Capture a,b and op at edge t; go to RUN with counter = N (MULT_CYCLES or DIV_CYCLES).
//    - busy=1 from cycle t+1 through t+N inclusive.
//    - At the edge ending cycle t+N: write hi/lo and return to IDLE. busy=0 in cycle t+N+1.
//    - hi/lo hold their old values throughout RUN.
//  - Stall unit contract: stall D when (busy | (start & md_op<=3)) and the D instr is an MD op.
//  - IDLE & start & md_op=4 (mthi): hi<=a at the next edge. lo unchanged, busy stays 0.
//  - IDLE & start & md_op=5 (mtlo): lo<=a at the next edge. hi unchanged, busy stays 0.
//  - start while busy: ignored, no state change. Stall logic must prevent this.
//  - md_op 6-7: ignored.
//  - Arithmetic (computed from captured operands, not live a/b):
//    - mult: {hi,lo} = $signed(a) * $signed(b), full 64-bit product.
//    - multu: {hi,lo} = a * b, unsigned 64-bit product.
//    - div: lo = signed quotient truncated toward zero; hi = remainder, sign follows dividend.
//    - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//    - divu: lo = a/b, hi = a%b, unsigned.
//    - b==0 for div/divu: full busy period still runs; hi/lo are left unchanged at completion.
//  - No flush input. An MD op in E is never flushed, because branches resolve in D.
// TESTING
//  - Reset mid-run: mult 3*4, assert reset in 3rd busy cycle -> busy=0, hi=lo=0 immediately
//    (async); no later write.
//  - Signed mult: a=0xFFFFFFFE(-2), b=3, op0 -> busy 5 cycles,
//    then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  - Unsigned mult: multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE
//    after 5 busy cycles.
//  - Signed div: div a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    divu 7/0 -> hi/lo unchanged.
//  - Move ops: mthi a=0x12345678 -> hi updated next edge, busy never 1.
//    mtlo then mult: lo overwritten only at mult end.
//  - Start while busy: div in progress, pulse start op=1 a=b=5 mid-run -> ignored;
//    final hi/lo match the div only.

Source files
------------

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding the architectural HI/LO registers.
// Mult/div run for a fixed number of busy cycles, then write HI/LO. mthi/mtlo write HI/LO in one cycle.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [31:0]     r_a, r_b, r_hi, r_lo;
  logic            w_launch, w_done, w_wr_en;
  logic [63:0]     w_prod_s, w_prod_u, w_res;
  logic            w_ovf;
  logic signed [31:0] w_sa, w_sdiv, w_q_s, w_r_s;
  logic [31:0]     w_udiv, w_q_u, w_r_u;

  assign w_launch = (r_state == S_IDLE) & start & ~md_op[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_launch) w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == S_RUN);
    w_done = (r_state == S_RUN) & (r_cnt == CW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_launch) begin
      r_cnt <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      r_op  <= md_op[1:0];
      r_a   <= a;
      r_b   <= b;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Sign-extending to 64 bits makes the truncated product the exact signed result.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};

  // Divisors are forced to 1 in the zero and overflow cases so the divider never sees them.
  assign w_ovf  = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_sa   = r_a;
  assign w_sdiv = ((r_b == 32'b0) || w_ovf) ? 32'sd1 : r_b;
  assign w_q_s  = w_ovf ? 32'sh8000_0000 : (w_sa / w_sdiv);
  assign w_r_s  = w_ovf ? 32'sd0 : (w_sa % w_sdiv);
  assign w_udiv = (r_b == 32'b0) ? 32'd1 : r_b;
  assign w_q_u  = r_a / w_udiv;
  assign w_r_u  = r_a % w_udiv;

  always_comb begin
    case (r_op)
      2'd0:    w_res = w_prod_s;
      2'd1:    w_res = w_prod_u;
      2'd2:    w_res = {w_r_s, w_q_s};
      default: w_res = {w_r_u, w_q_u};
    endcase
  end

  assign w_wr_en = ~r_op[1] | (r_b != 32'b0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (w_wr_en) begin
        r_hi <= w_res[63:32];
        r_lo <= w_res[31:0];
      end
    end else if ((r_state == S_IDLE) && start) begin
      if (md_op == 3'd4) r_hi <= a;
      if (md_op == 3'd5) r_lo <= a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;
endmodule
